// File: rtl/instruction_fetch.sv
// Instruction fetch stage: drives the PC, captures memory read data into a
// one-entry instruction register toward decode, and handles redirects and halting.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MEM_SIZE = 500
) (
  input  logic        Clk,
  input  logic        Rst,
  output logic [31:0] programCounter,
  input  logic [31:0] instruction,
  input  logic        branchTaken,
  input  logic [31:0] branchTarget,
  input  logic        irReady,
  output logic        irValid,
  output logic [31:0] irData,
  output logic [31:0] irPC,
  output logic        halted,
  output logic        fault
);

  typedef enum logic [1:0] {WAIT, FETCH, HOLD, HALT} state_t;

  localparam logic [31:0] LAST_PC = 32'(MEM_SIZE - 4);

  state_t      state, state_nxt;
  logic [31:0] pc_nxt, data_nxt, ipc_nxt;
  logic        vld_nxt, halt_nxt, fault_nxt;
  logic        can_capture, end_of_mem;

  assign can_capture = !irValid || irReady;
  assign end_of_mem  = programCounter > LAST_PC;

  always_comb begin
    state_nxt = state;
    pc_nxt    = programCounter;
    data_nxt  = irData;
    ipc_nxt   = irPC;
    vld_nxt   = irValid;
    halt_nxt  = halted;
    fault_nxt = fault;
    case (state)
      WAIT: state_nxt = FETCH;
      FETCH, HOLD: begin
        // Redirects win over capture; a word accepted alongside a branch is simply dropped.
        if (branchTaken) begin
          vld_nxt = 1'b0;
          if (branchTarget[1:0] != 2'b00) begin
            fault_nxt = 1'b1;
            halt_nxt  = 1'b1;
            state_nxt = HALT;
          end else begin
            pc_nxt    = branchTarget;
            state_nxt = FETCH;
          end
        end else if (can_capture) begin
          if (instruction == 32'h0 || end_of_mem) begin
            vld_nxt   = 1'b0;
            halt_nxt  = 1'b1;
            state_nxt = HALT;
          end else begin
            data_nxt  = instruction;
            ipc_nxt   = programCounter;
            vld_nxt   = 1'b1;
            pc_nxt    = programCounter + 32'd4;
            state_nxt = FETCH;
          end
        end else begin
          state_nxt = HOLD;
        end
      end
      HALT: if (irValid && irReady) vld_nxt = 1'b0;
      default: state_nxt = WAIT;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state          <= WAIT;
      programCounter <= RESET_PC;
      irValid        <= 1'b0;
      irData         <= 32'h0;
      irPC           <= 32'h0;
      halted         <= 1'b0;
      fault          <= 1'b0;
    end else begin
      state          <= state_nxt;
      programCounter <= pc_nxt;
      irValid        <= vld_nxt;
      irData         <= data_nxt;
      irPC           <= ipc_nxt;
      halted         <= halt_nxt;
      fault          <= fault_nxt;
    end
  end

endmodule
